// File: rtl/mult_arbiter_if.sv
// Bus between the shared-multiplier arbiter and the effect stages / external multiplier.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mult_arbiter_if #(
    parameter int WIDTH   = 24,
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic                     en;
    logic                     sample_tick;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [2*WIDTH-1:0]       mul_p;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_data;
    logic [CNT_W-1:0]         ops_last;
    logic                     overrun;

    modport slave (
        input  en, sample_tick, req_valid, req_a, req_b, mul_p,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, ops_last, overrun
    );

    modport master (
        output en, sample_tick, req_valid, req_a, req_b, mul_p,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, ops_last, overrun
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one external multiplier among NUM_REQ requesters,
// tags each product with its owner, and tracks the per-sample multiply budget.
module mult_arbiter #(
    parameter int WIDTH    = 24,
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 2,
    parameter int CNT_W    = 8
) (
    input logic          clk,
    input logic          rst,
    mult_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ID_W-1:0]     rr_q, rr_d;
    logic [MULT_LAT-1:0] tag_v_q, tag_v_d;
    logic [ID_W-1:0]     tag_id_q [MULT_LAT];
    logic [ID_W-1:0]     tag_id_d [MULT_LAT];
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    ops_last_q, ops_last_d;
    logic                overrun_q, overrun_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_id;
    logic                transfer;
    logic [NUM_REQ-1:0]  ready;
    logic [CNT_W-1:0]    count_inc;
    int                  idx;

    // Scan from the round-robin pointer upward, wrapping, and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
        transfer = bus.en & ~rst & grant_found;
        ready    = '0;
        if (transfer) ready[grant_id] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign bus.mul_a     = transfer ? bus.req_a[int'(grant_id)*WIDTH +: WIDTH] : '0;
    assign bus.mul_b     = transfer ? bus.req_b[int'(grant_id)*WIDTH +: WIDTH] : '0;

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

    always_comb begin
        rr_d       = rr_q;
        tag_v_d    = tag_v_q;
        tag_id_d   = tag_id_q;
        count_d    = count_q;
        ops_last_d = ops_last_q;
        overrun_d  = overrun_q;

        if (transfer) begin
            rr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end

        // Tags move in lockstep with the external delay chain, which shares the same enable.
        if (bus.en) begin
            tag_v_d[0]  = transfer;
            tag_id_d[0] = grant_id;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v_d[i]  = tag_v_q[i-1];
                tag_id_d[i] = tag_id_q[i-1];
            end
        end

        if (bus.sample_tick) begin
            ops_last_d = transfer ? count_inc : count_q;
            count_d    = '0;
            if ((|(bus.req_valid & ~ready)) || (|tag_v_q)) overrun_d = 1'b1;
        end else if (transfer) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '{default: '0};
            count_q    <= '0;
            ops_last_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            count_q    <= count_d;
            ops_last_q <= ops_last_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.rsp_valid = tag_v_q[MULT_LAT-1];
    assign bus.rsp_id    = tag_id_q[MULT_LAT-1];
    assign bus.rsp_data  = bus.mul_p;
    assign bus.ops_last  = ops_last_q;
    assign bus.overrun   = overrun_q;
endmodule
